// File: rtl/common_pkg.sv
// Shared sizing and types for the CLIC pending stage and its arbiter.
// Index is one bit wider than strictly needed so that out-of-range indices exist and can be rejected.
package common_pkg;

  localparam int N_VEC     = 4;
  localparam int PRIO_BITS = 3;
  localparam int IDX_BITS  = $clog2(N_VEC) + 1;

  typedef logic [PRIO_BITS-1:0] Prio;
  typedef logic [IDX_BITS-1:0]  Index;
  typedef Prio  [N_VEC-1:0]     Entries;

endpackage

// File: rtl/can_clic_pend_if.sv
// Configuration, software pending-bit and take bus of the CLIC pending stage.
interface can_clic_pend_if #(
  parameter int PRIO_BITS = common_pkg::PRIO_BITS,
  parameter int IDX_BITS  = common_pkg::IDX_BITS
);

  logic                 cfg_we;
  logic [IDX_BITS-1:0]  cfg_index;
  logic                 cfg_ie;
  logic                 cfg_edge;
  logic [PRIO_BITS-1:0] cfg_prio;

  logic                 sw_we;
  logic [IDX_BITS-1:0]  sw_index;
  logic                 sw_set;

  logic                 take_i;
  logic [IDX_BITS-1:0]  take_index_i;

  modport master (
    output cfg_we, cfg_index, cfg_ie, cfg_edge, cfg_prio,
    output sw_we, sw_index, sw_set,
    output take_i, take_index_i
  );

  modport slave (
    input cfg_we, cfg_index, cfg_ie, cfg_edge, cfg_prio,
    input sw_we, sw_index, sw_set,
    input take_i, take_index_i
  );

endinterface

// File: rtl/can_clic_sync.sv
// Two-flop synchronizer for the asynchronous interrupt lines.
module can_clic_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/can_clic_pend.sv
// Per-vector pending/enable/priority state of the CLIC, producing the arbiter's priority entries.
// Level vectors follow the synchronized line directly; edge vectors latch rises until taken or cleared.
module can_clic_pend #(
  parameter int N_VEC     = common_pkg::N_VEC,
  parameter int PRIO_BITS = common_pkg::PRIO_BITS,
  parameter int IDX_BITS  = common_pkg::IDX_BITS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_VEC-1:0]                    irq_i,
  can_clic_pend_if.slave                      bus,
  output logic [N_VEC-1:0][PRIO_BITS-1:0]     entries_o,
  output logic [N_VEC-1:0]                    pend_o
);

  import common_pkg::*;

  logic [N_VEC-1:0]                irq_s;
  logic [N_VEC-1:0]                irq_q;
  logic [N_VEC-1:0]                rise;

  logic [N_VEC-1:0]                cfg_hit;
  logic [N_VEC-1:0]                sw_set_hit;
  logic [N_VEC-1:0]                sw_clr_hit;
  logic [N_VEC-1:0]                take_hit;

  logic [N_VEC-1:0]                pend_q, pend_d;
  logic [N_VEC-1:0]                ie_q, ie_d;
  logic [N_VEC-1:0]                edge_q, edge_d;
  logic [N_VEC-1:0][PRIO_BITS-1:0] prio_q, prio_d;
  logic [N_VEC-1:0]                pend;

  can_clic_sync #(
    .WIDTH (N_VEC)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (irq_i),
    .q_o   (irq_s)
  );

  assign rise = irq_s & ~irq_q;

  // Index compare is full width, so indices >= N_VEC never match any vector.
  for (genvar gi = 0; gi < N_VEC; gi++) begin : g_vec
    assign cfg_hit[gi]    = bus.cfg_we && (bus.cfg_index == IDX_BITS'(gi));
    assign sw_set_hit[gi] = bus.sw_we && bus.sw_set && (bus.sw_index == IDX_BITS'(gi));
    assign sw_clr_hit[gi] = bus.sw_we && !bus.sw_set && (bus.sw_index == IDX_BITS'(gi));
    assign take_hit[gi]   = bus.take_i && (bus.take_index_i == IDX_BITS'(gi));

    assign pend[gi]      = edge_q[gi] ? pend_q[gi] : irq_s[gi];
    assign entries_o[gi] = (pend[gi] && ie_q[gi]) ? prio_q[gi] : '0;
  end

  assign pend_o = pend;

  always_comb begin
    pend_d = pend_q;
    ie_d   = ie_q;
    edge_d = edge_q;
    prio_d = prio_q;
    for (int v = 0; v < N_VEC; v++) begin
      // Level vectors keep tracking irq_s so a switch to edge mode retains the current level.
      if (!edge_q[v]) begin
        pend_d[v] = irq_s[v];
      end else if (rise[v] || sw_set_hit[v]) begin
        pend_d[v] = 1'b1;
      end else if (take_hit[v] || sw_clr_hit[v]) begin
        pend_d[v] = 1'b0;
      end
      if (cfg_hit[v]) begin
        ie_d[v]   = bus.cfg_ie;
        edge_d[v] = bus.cfg_edge;
        prio_d[v] = bus.cfg_prio;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q  <= '0;
      pend_q <= '0;
      ie_q   <= '0;
      edge_q <= '0;
      prio_q <= '0;
    end else begin
      irq_q  <= irq_s;
      pend_q <= pend_d;
      ie_q   <= ie_d;
      edge_q <= edge_d;
      prio_q <= prio_d;
    end
  end

endmodule
